upcounter4bit_mod: RTL and testbench
====================================

// Module: upcounter4bit_mod
// PURPOSE
//  Parameterised modulo up-counter: the count-up counterpart of the team's 4-bit down-counter.
//  Increments on enabled, prescaled ticks from 0 to MODULUS-1, then wraps or saturates.
//  Provides load/clear, a terminal-count flag, a wrap pulse and a sticky overflow flag.
//  Used as an event/timebase counter; the wrap pulse feeds cascaded counters downstream.
// PARAMETERS
//  WIDTH     4   count width in bits; MODULUS must be <= 2**WIDTH
//  MODULUS   16  count range 0..MODULUS-1; legal range 2..2**WIDTH
//  PRESCALE  1   increment once per PRESCALE enabled cycles; 1 = every enabled cycle
//  MODE      CNT_WRAP  CNT_WRAP = roll to 0 after MODULUS-1; CNT_SAT = hold at MODULUS-1
// PORTS
//  clk         in   1      single clock; all state is updated on posedge
//  reset       in   1      asynchronous, active-high reset
//  clear       in   1      synchronous clear of count, prescaler and overflow
//  load        in   1      synchronous load of load_val
//  load_val    in   WIDTH  value to load
//  enable      in   1      count enable; feeds the prescaler
//  count       out  WIDTH  current count (registered)
//  tc          out  1      terminal count: combinational (count == MODULUS-1)
//  wrap_pulse  out  1      registered 1-cycle pulse after a wrap (CNT_WRAP mode only)
//  overflow    out  1      sticky flag: increment requested at MODULUS-1
//  load_err    out  1      registered 1-cycle pulse: load_val >= MODULUS was clamped
// BEHAVIOUR
//  Reset (async): count=0, wrap_pulse=0, overflow=0, load_err=0, prescaler=0.
//    Reset asserted mid-run aborts the run immediately; no partial update occurs.
//  Priority each cycle: reset > clear > load > increment.
//  clear: count=0, prescaler=0, overflow=0; any load or increment in the same cycle is ignored.
//  load: count=load_val, prescaler=0; overflow is unchanged.
//    If load_val >= MODULUS, count=MODULUS-1 and load_err pulses on the next cycle.
//    A load in the same cycle as an increment suppresses the increment.
//  tick (prescaler): PRESCALE=1 -> tick = enable.
//    Otherwise an internal counter 0..PRESCALE-1 advances on each enabled cycle.
//    tick = enable && (prescaler == PRESCALE-1); the prescaler then wraps to 0.
//    enable low freezes the prescaler.
//  increment when tick: count != MODULUS-1 -> count+1 on the next edge (1-cycle latency).
//  At count == MODULUS-1 with tick:
//    CNT_WRAP -> count=0, wrap_pulse=1 for exactly one cycle, overflow set.
//    CNT_SAT  -> count holds, overflow set, wrap_pulse stays 0.
//  overflow stays set until clear or reset.
//  Arithmetic is unsigned WIDTH-bit; there is no natural 2**WIDTH rollover unless MODULUS=2**WIDTH.
//  Back-to-back wraps, e.g. MODULUS=2 with PRESCALE=1, give wrap_pulse every 2nd cycle.
//  Elaboration asserts: MODULUS<2, MODULUS>2**WIDTH and PRESCALE<1 are fatal.
// STRUCTURE
//  counter_pkg: typedef enum {CNT_WRAP, CNT_SAT} cnt_mode_e;
//    function clog2_min1() used for prescaler width.
//  Sub-module tick_prescaler #(PRESCALE):
//    ports clk, reset, clear (clear|load), enable -> tick.
//    Pass-through when PRESCALE=1.
//  Top: count register, terminal compare, wrap/overflow/load_err logic.
// TESTING (WIDTH=4, MODULUS=16, PRESCALE=1, CNT_WRAP unless noted)
//  1. Reset 2 cycles, then enable=1 for 17 cycles
//     -> count 0,1..15,0; tc high at 15; wrap_pulse 1 cycle after 15->0; overflow=1.
//  2. MODULUS=10, CNT_SAT, enable=1 for 12 cycles
//     -> count saturates at 9, tc=1, overflow=1, wrap_pulse never asserts.
//  3. PRESCALE=3, enable=1 for 9 cycles
//     -> count steps 0->1->2->3 every 3rd cycle; enable low for 2 cycles freezes count and prescaler.
//  4. count=5, assert load=1 (load_val=12) with enable=1 -> count=12, no increment.
//     MODULUS=10, load_val=13 -> count=9, load_err pulses once.
//  5. Assert clear and load together at count=7 -> count=0, overflow cleared.
//     Clear after overflow=1 -> overflow=0.
//  6. Assert reset asynchronously mid-cycle at count=11 -> count=0 before the next edge.
//     Release reset -> counting resumes from 0 on the first enabled edge.

Source files
------------

// File: rtl/upcounter4bit_mod_pkg.sv
// Shared types and helpers for the modulo up-counter and its prescaler.
package counter_pkg;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/upcounter4bit_mod_if.sv
// Control/status bundle between a counter and whoever drives it.
interface upcounter4bit_mod_if #(parameter int WIDTH = 4);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_pulse;
  logic             overflow;
  logic             load_err;

  modport master (output clear, load, load_val, enable,
                  input  count, tc, wrap_pulse, overflow, load_err);
  modport slave  (input  clear, load, load_val, enable,
                  output count, tc, wrap_pulse, overflow, load_err);
endinterface

// File: rtl/upcounter4bit_mod_tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick fires on the last enabled cycle of each group.
module tick_prescaler import counter_pkg::*; #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  if (PRESCALE == 1) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, reset, clear};
    assign tick = enable;
  end else begin : g_div
    localparam int PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] pre_q;

    assign tick = enable && (pre_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset)       pre_q <= '0;
      else if (clear)  pre_q <= '0;
      else if (enable) pre_q <= (pre_q == LAST) ? '0 : pre_q + 1'b1;
    end
  end
endmodule

// File: rtl/upcounter4bit_mod.sv
// Modulo up-counter with prescaled enable, load clamp, terminal count, wrap pulse and sticky overflow.
module upcounter4bit_mod import counter_pkg::*; #(
  parameter int        WIDTH    = 4,
  parameter int        MODULUS  = 16,
  parameter int        PRESCALE = 1,
  parameter cnt_mode_e MODE     = CNT_WRAP
) (
  input logic               clk,
  input logic               reset,
  upcounter4bit_mod_if.slave bus
);
  if (MODULUS < 2)              begin : g_bad_mod_lo $fatal(1, "MODULUS must be >= 2");          end
  if (MODULUS > (1 << WIDTH))   begin : g_bad_mod_hi $fatal(1, "MODULUS must be <= 2**WIDTH");   end
  if (PRESCALE < 1)             begin : g_bad_pre    $fatal(1, "PRESCALE must be >= 1");         end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the load range check.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q, ovf_q, lerr_q;
  logic             tick, at_max;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.clear | bus.load),
    .enable (bus.enable),
    .tick   (tick)
  );

  assign at_max = (count_q == MAX_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
      if (bus.clear) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (bus.load) begin
        if ({1'b0, bus.load_val} >= MOD_W) begin
          count_q <= MAX_CNT;
          lerr_q  <= 1'b1;
        end else begin
          count_q <= bus.load_val;
        end
      end else if (tick) begin
        if (at_max) begin
          ovf_q <= 1'b1;
          if (MODE == CNT_WRAP) begin
            count_q <= '0;
            wrap_q  <= 1'b1;
          end
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = at_max;
  assign bus.wrap_pulse = wrap_q;
  assign bus.overflow   = ovf_q;
  assign bus.load_err   = lerr_q;
endmodule

// File: tb/tb_upcounter4bit_mod.sv
// Bench for upcounter4bit_mod: four parameter sets, directed tables/sequences plus random vs. model.
module tb_upcounter4bit_mod;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  upcounter4bit_mod_if #(.WIDTH(4)) ifa ();
  upcounter4bit_mod_if #(.WIDTH(4)) ifb ();
  upcounter4bit_mod_if #(.WIDTH(4)) ifc ();
  upcounter4bit_mod_if #(.WIDTH(4)) ifd ();

  upcounter4bit_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .MODE(CNT_WRAP)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  upcounter4bit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .MODE(CNT_SAT))  u_b (.clk(clk), .reset(reset), .bus(ifb));
  upcounter4bit_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(3), .MODE(CNT_WRAP)) u_c (.clk(clk), .reset(reset), .bus(ifc));
  upcounter4bit_mod #(.WIDTH(4), .MODULUS(2),  .PRESCALE(1), .MODE(CNT_WRAP)) u_d (.clk(clk), .reset(reset), .bus(ifd));

  int n_cmp = 0;
  int n_fail = 0;

  // Per-instance configuration for the reference model.
  int cfg_mod [4] = '{16, 10, 16, 2};
  int cfg_pre [4] = '{1, 1, 3, 1};
  bit cfg_sat [4] = '{0, 1, 0, 0};

  typedef struct {
    int cnt;
    int pre;
    bit ovf;
    bit wrap;
    bit lerr;
  } mstate_t;

  mstate_t ms [4];

  typedef struct {
    bit clr; bit ld; int lv; bit en;
    int cnt; bit tc; bit wrap; bit ovf; bit lerr;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mkv(bit clr, bit ld, int lv, bit en, int cnt, bit tc, bit wrap, bit ovf, bit lerr);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = en;
    v.cnt = cnt; v.tc = tc; v.wrap = wrap; v.ovf = ovf; v.lerr = lerr;
    return v;
  endfunction

  // Behavioural model: the counting rules stated as plain integer arithmetic.
  function automatic mstate_t mstep(mstate_t s, int k, bit clr, bit ld, int lv, bit en);
    mstate_t n = s;
    bit tick;
    n.wrap = 0;
    n.lerr = 0;
    if (clr) begin
      n.cnt = 0; n.pre = 0; n.ovf = 0;
    end else if (ld) begin
      n.pre = 0;
      if (lv >= cfg_mod[k]) begin
        n.cnt = cfg_mod[k] - 1; n.lerr = 1;
      end else n.cnt = lv;
    end else if (en) begin
      n.pre = (s.pre + 1) % cfg_pre[k];
      tick = (n.pre == 0);
      if (tick) begin
        if (s.cnt == cfg_mod[k] - 1) begin
          n.ovf = 1;
          if (!cfg_sat[k]) begin
            n.cnt = 0; n.wrap = 1;
          end
        end else n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int k, input bit clr, input bit ld, input int lv, input bit en);
    case (k)
      0: begin ifa.clear = clr; ifa.load = ld; ifa.load_val = 4'(lv); ifa.enable = en; end
      1: begin ifb.clear = clr; ifb.load = ld; ifb.load_val = 4'(lv); ifb.enable = en; end
      2: begin ifc.clear = clr; ifc.load = ld; ifc.load_val = 4'(lv); ifc.enable = en; end
      default: begin ifd.clear = clr; ifd.load = ld; ifd.load_val = 4'(lv); ifd.enable = en; end
    endcase
  endtask

  task automatic get(input int k, output int cnt, output bit tc, output bit w, output bit o, output bit l);
    case (k)
      0: begin cnt = int'(ifa.count); tc = ifa.tc; w = ifa.wrap_pulse; o = ifa.overflow; l = ifa.load_err; end
      1: begin cnt = int'(ifb.count); tc = ifb.tc; w = ifb.wrap_pulse; o = ifb.overflow; l = ifb.load_err; end
      2: begin cnt = int'(ifc.count); tc = ifc.tc; w = ifc.wrap_pulse; o = ifc.overflow; l = ifc.load_err; end
      default: begin cnt = int'(ifd.count); tc = ifd.tc; w = ifd.wrap_pulse; o = ifd.overflow; l = ifd.load_err; end
    endcase
  endtask

  task automatic chk_all(input string nm, input int k, input int cnt, input bit tc, input bit w, input bit o, input bit l);
    int a_cnt; bit a_tc, a_w, a_o, a_l;
    get(k, a_cnt, a_tc, a_w, a_o, a_l);
    chk($sformatf("%s.count", nm), a_cnt, cnt);
    chk($sformatf("%s.tc", nm), int'(a_tc), int'(tc));
    chk($sformatf("%s.wrap", nm), int'(a_w), int'(w));
    chk($sformatf("%s.ovf", nm), int'(a_o), int'(o));
    chk($sformatf("%s.lerr", nm), int'(a_l), int'(l));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    for (int k = 0; k < 4; k++) drive(k, 0, 0, 0, 0);

    // Table for MODULUS=10 saturating counter: saturation, load clamp, clear priority.
    for (int i = 1; i <= 12; i++) begin
      c = (i < 9) ? i : 9;
      tbl[i-1] = mkv(0, 0, 0, 1, c, c == 9, 0, i >= 10, 0);
    end
    tbl[12] = mkv(0, 1, 13, 1, 9, 1, 0, 1, 1);
    tbl[13] = mkv(0, 0, 0,  0, 9, 1, 0, 1, 0);
    tbl[14] = mkv(0, 1, 5,  1, 5, 0, 0, 1, 0);
    tbl[15] = mkv(0, 0, 0,  1, 6, 0, 0, 1, 0);
    tbl[16] = mkv(1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[17] = mkv(0, 1, 7,  0, 7, 0, 0, 0, 0);
    tbl[18] = mkv(1, 1, 3,  1, 0, 0, 0, 0, 0);
    tbl[19] = mkv(0, 1, 9,  0, 9, 1, 0, 0, 0);
    tbl[20] = mkv(0, 1, 10, 0, 9, 1, 0, 0, 1);

    // Reset for two cycles, then check the reset state everywhere.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) chk_all($sformatf("reset[%0d]", k), k, 0, 0, 0, 0, 0);

    // Full wrap on the 16-count instance.
    drive(0, 0, 0, 0, 1);
    for (int i = 1; i <= 17; i++) begin
      step();
      chk_all($sformatf("wrap16[%0d]", i), 0, i % 16, (i % 16) == 15, i == 16, i >= 16, 0);
    end

    // Table-driven saturating sequence.
    for (int i = 0; i < 21; i++) begin
      drive(1, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en);
      step();
      chk_all($sformatf("tbl[%0d]", i), 1, tbl[i].cnt, tbl[i].tc, tbl[i].wrap, tbl[i].ovf, tbl[i].lerr);
    end
    drive(1, 0, 0, 0, 0);

    // Load beats increment; clear+load clears overflow.
    drive(0, 0, 1, 5, 0);  step(); chk("ld5.count", int'(ifa.count), 5);
    drive(0, 0, 1, 12, 1); step(); chk_all("ld12en", 0, 12, 0, 0, 1, 0);
    drive(0, 0, 1, 7, 0);  step(); chk_all("ld7", 0, 7, 0, 0, 1, 0);
    drive(0, 1, 1, 3, 1);  step(); chk_all("clrld", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Prescale by 3, then a two-cycle enable gap must freeze the prescaler.
    drive(2, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("pre3[%0d]", i), int'(ifc.count), i / 3);
    end
    drive(2, 0, 0, 0, 0);
    step(); step();
    chk("pre3.frozen", int'(ifc.count), 3);
    drive(2, 0, 0, 0, 1);
    step(); chk("pre3.resume1", int'(ifc.count), 3);
    step(); chk("pre3.resume2", int'(ifc.count), 3);
    step(); chk("pre3.resume3", int'(ifc.count), 4);
    drive(2, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle.
    drive(0, 0, 1, 11, 0); step(); chk("pre_rst.count", int'(ifa.count), 11);
    drive(0, 0, 0, 0, 1);
    #2 reset = 1'b1;
    #1 chk("async_rst.count", int'(ifa.count), 0);
    #2 reset = 1'b0;
    step(); chk("post_rst.count", int'(ifa.count), 1);
    drive(0, 0, 0, 0, 0);

    // MODULUS=2: wrap_pulse on every second cycle.
    drive(3, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_all($sformatf("mod2[%0d]", i), 3, i % 2, (i % 2) == 1, (i % 2) == 0, i >= 2, 0);
    end

    // Random stimulus against the model on all four configurations.
    for (int k = 0; k < 4; k++) drive(k, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) ms[k] = '{cnt: 0, pre: 0, ovf: 0, wrap: 0, lerr: 0};
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < 4; k++) begin
        bit clr, ld, en; int lv;
        clr = ($urandom_range(0, 19) == 0);
        ld  = ($urandom_range(0, 9) == 0);
        lv  = int'($urandom_range(0, 15));
        en  = ($urandom_range(0, 9) < 7);
        drive(k, clr, ld, lv, en);
        ms[k] = mstep(ms[k], k, clr, ld, lv, en);
      end
      step();
      for (int k = 0; k < 4; k++)
        chk_all($sformatf("rnd[%0d].%0d", t, k), k, ms[k].cnt, ms[k].cnt == cfg_mod[k] - 1,
                ms[k].wrap, ms[k].ovf, ms[k].lerr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule
